// File: rtl/exec_pkg.sv
// Shared types and constants for the exec_pipe integer execute pipeline.
// Contents:
//   alu_op_e    - ALU operation selector, including the RV64 W variants
//   OP_*        - major opcodes accepted by the decoder
//   decoded_t   - decoder output bundle
//   is_word_op  - true for ops that compute on 32 bits and sign-extend
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW
  } alu_op_e;

  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;

  typedef struct packed {
    alu_op_e     op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;      // raw I-immediate, sign-extended at the operand mux
    logic        use_imm;
    logic        wb_en;
    logic        illegal;
  } decoded_t;

  function automatic logic is_word_op(input alu_op_e op);
    return op inside {ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW};
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational integer ALU for exec_pipe.
// Ports:
//   op - operation select (alu_op_e)
//   a  - operand A (XLEN)
//   b  - operand B (XLEN); the low bits supply the shift amount
//   y  - result (XLEN); W ops are sign-extended from bit 31
module exec_alu
  import exec_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  // Full-width shifts use 6 bits on RV64 and 5 bits on RV32.
  localparam int SW = (XLEN == 64) ? 6 : 5;

  logic [SW-1:0] sh;
  logic [4:0]    wsh;
  logic [31:0]   w;

  always_comb begin
    // NOTE: every output of this block gets a default first so that no
    // path through the case leaves a variable unassigned (no latch).
    sh  = b[SW-1:0];
    wsh = b[4:0];
    w   = '0;
    y   = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << sh;
      ALU_SLT:  y = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: y = XLEN'(a < b);
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> sh;
      ALU_SRA:  y = $signed(a) >>> sh;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      ALU_ADDW: w = a[31:0] + b[31:0];
      ALU_SUBW: w = a[31:0] - b[31:0];
      ALU_SLLW: w = a[31:0] << wsh;
      ALU_SRLW: w = a[31:0] >> wsh;
      ALU_SRAW: w = $signed(a[31:0]) >>> wsh;
      default:  y = '0;
    endcase
    if (is_word_op(op)) y = XLEN'($signed(w));
  end

endmodule

// File: rtl/exec_pipe.sv
// Two-stage RV32I/RV64I register-register / register-immediate execute pipe.
// S1 holds a decoded instruction with its operands; S2 holds the result.
// Ports:
//   clk, rst               - clock (rising edge), synchronous active-low reset
//   instr_valid/ready/instr - instruction input handshake
//   result_valid/ready     - result output handshake
//   result, result_rd      - ALU result (0 when illegal) and destination
//   result_illegal         - instruction was not a supported ALU op
//   dbg_addr, dbg_data     - combinational register file read port
module exec_pipe
  import exec_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd,
  output logic            result_illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int         AW      = $clog2(NREGS);
  localparam logic [5:0] NREGS_W = 6'(NREGS);

  logic [XLEN-1:0] regs [NREGS];

  decoded_t        dec;
  logic            s1_valid, s1_wb_en, s1_illegal;
  alu_op_e         s1_op;
  logic [4:0]      s1_rd;
  logic [XLEN-1:0] s1_a, s1_b, alu_y;
  logic [XLEN-1:0] op_a, op_b;
  logic            s1_adv, accept, fwd_a, fwd_b;

  // Out-of-range indices only occur on illegal instructions; return 0.
  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a);
    if (a == 5'd0 || {1'b0, a} >= NREGS_W) return '0;
    return regs[a[AW-1:0]];
  endfunction

  // ---------------------------------------------------------------- decode
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       legal, sh_lo_ok, sh_ar_ok;

  always_comb begin
    opcode      = instr[6:0];
    f3          = instr[14:12];
    f7          = instr[31:25];
    dec         = '0;
    dec.op      = ALU_ADD;
    dec.rd      = instr[11:7];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.imm     = instr[31:20];
    legal       = 1'b1;
    // RV64 full-width shift immediates carry a 6-bit shamt, so only the
    // top six bits form the funct field there.
    sh_lo_ok = (XLEN == 64) ? (instr[31:26] == 6'b000000) : (f7 == 7'b0000000);
    sh_ar_ok = (XLEN == 64) ? (instr[31:26] == 6'b010000) : (f7 == 7'b0100000);
    case (opcode)
      OP: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'd0: dec.op = ALU_ADD;
            3'd1: dec.op = ALU_SLL;
            3'd2: dec.op = ALU_SLT;
            3'd3: dec.op = ALU_SLTU;
            3'd4: dec.op = ALU_XOR;
            3'd5: dec.op = ALU_SRL;
            3'd6: dec.op = ALU_OR;
            default: dec.op = ALU_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'd0) dec.op = ALU_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'd5) dec.op = ALU_SRA;
        else legal = 1'b0;
      end
      OP_IMM: begin
        dec.use_imm = 1'b1;
        case (f3)
          3'd0: dec.op = ALU_ADD;
          3'd1: begin dec.op = ALU_SLL; legal = sh_lo_ok; end
          3'd2: dec.op = ALU_SLT;
          3'd3: dec.op = ALU_SLTU;
          3'd4: dec.op = ALU_XOR;
          3'd5: begin
            dec.op = sh_ar_ok ? ALU_SRA : ALU_SRL;
            legal  = sh_lo_ok || sh_ar_ok;
          end
          3'd6: dec.op = ALU_OR;
          default: dec.op = ALU_AND;
        endcase
      end
      OP_32: begin
        if (XLEN != 64) legal = 1'b0;
        else if (f7 == 7'b0000000 && f3 == 3'd0) dec.op = ALU_ADDW;
        else if (f7 == 7'b0000000 && f3 == 3'd1) dec.op = ALU_SLLW;
        else if (f7 == 7'b0000000 && f3 == 3'd5) dec.op = ALU_SRLW;
        else if (f7 == 7'b0100000 && f3 == 3'd0) dec.op = ALU_SUBW;
        else if (f7 == 7'b0100000 && f3 == 3'd5) dec.op = ALU_SRAW;
        else legal = 1'b0;
      end
      OP_IMM_32: begin
        dec.use_imm = 1'b1;
        if (XLEN != 64) legal = 1'b0;
        else if (f3 == 3'd0) dec.op = ALU_ADDW;
        else if (f7 == 7'b0000000 && f3 == 3'd1) dec.op = ALU_SLLW;
        else if (f7 == 7'b0000000 && f3 == 3'd5) dec.op = ALU_SRLW;
        else if (f7 == 7'b0100000 && f3 == 3'd5) dec.op = ALU_SRAW;
        else legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    if ({1'b0, dec.rd} >= NREGS_W || {1'b0, dec.rs1} >= NREGS_W ||
        (!dec.use_imm && {1'b0, dec.rs2} >= NREGS_W))
      legal = 1'b0;
    dec.illegal = !legal;
    dec.wb_en   = legal;
  end

  // ------------------------------------------------- operands / forwarding
  // S1's result is written back on the same edge the next instruction is
  // captured, so a dependent instruction must take it straight from the ALU.
  assign fwd_a = s1_valid && s1_wb_en && s1_rd != 5'd0 && s1_rd == dec.rs1;
  assign fwd_b = s1_valid && s1_wb_en && s1_rd != 5'd0 && s1_rd == dec.rs2;
  assign op_a  = fwd_a ? alu_y : rf_read(dec.rs1);
  assign op_b  = dec.use_imm ? XLEN'($signed(dec.imm))
               : (fwd_b ? alu_y : rf_read(dec.rs2));

  exec_alu #(.XLEN(XLEN)) u_alu (.op(s1_op), .a(s1_a), .b(s1_b), .y(alu_y));

  // ----------------------------------------------------------- flow control
  assign s1_adv      = s1_valid && (!result_valid || result_ready);
  assign instr_ready = !s1_valid || s1_adv;
  assign accept      = instr_valid && instr_ready;
  assign dbg_data    = rf_read(dbg_addr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid       <= 1'b0;
      s1_op          <= ALU_ADD;
      s1_rd          <= '0;
      s1_wb_en       <= 1'b0;
      s1_illegal     <= 1'b0;
      s1_a           <= '0;
      s1_b           <= '0;
      result_valid   <= 1'b0;
      result         <= '0;
      result_rd      <= '0;
      result_illegal <= 1'b0;
      // NOTE: the register file is architecturally zeroed by reset, so the
      // array is cleared here even though that rules out a RAM macro.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every register
      // samples pre-edge values (writeback and forwarding rely on that).
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_op      <= dec.op;
        s1_rd      <= dec.rd;
        s1_wb_en   <= dec.wb_en;
        s1_illegal <= dec.illegal;
        s1_a       <= op_a;
        s1_b       <= op_b;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        result_valid   <= 1'b1;
        result         <= s1_illegal ? '0 : alu_y;
        result_rd      <= s1_rd;
        result_illegal <= s1_illegal;
        if (s1_wb_en && s1_rd != 5'd0) regs[s1_rd[AW-1:0]] <= alu_y;
      end else if (result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exec_pipe.sv
// Directed bench for exec_pipe. Three instances share one stimulus stream:
// the default RV64/32-register build, an RV32 build and an RV64E (16 reg)
// build, so configuration-specific illegal cases are seen side by side.
module tb_exec_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        result_ready = 1'b1;
  logic [4:0]  dbg_addr = '0;

  logic        rdy64, rv64, ill64; logic [63:0] res64, dbg64; logic [4:0] rd64;
  logic        rdy32, rv32, ill32; logic [31:0] res32, dbg32; logic [4:0] rd32;
  logic        rdy16, rv16, ill16; logic [63:0] res16, dbg16; logic [4:0] rd16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exec_pipe #(.XLEN(64), .NREGS(32)) u64 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(rdy64),
    .instr(instr), .result_valid(rv64), .result_ready(result_ready),
    .result(res64), .result_rd(rd64), .result_illegal(ill64),
    .dbg_addr(dbg_addr), .dbg_data(dbg64));

  exec_pipe #(.XLEN(32), .NREGS(32)) u32 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(rdy32),
    .instr(instr), .result_valid(rv32), .result_ready(result_ready),
    .result(res32), .result_rd(rd32), .result_illegal(ill32),
    .dbg_addr(dbg_addr), .dbg_data(dbg32));

  exec_pipe #(.XLEN(64), .NREGS(16)) u16 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(rdy16),
    .instr(instr), .result_valid(rv16), .result_ready(result_ready),
    .result(res16), .result_rd(rd16), .result_illegal(ill16),
    .dbg_addr(dbg_addr), .dbg_data(dbg16));

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Offer one instruction, wait (bounded) for acceptance, then one more edge
  // so the result sits in the output stage.
  task automatic issue_one(input logic [31:0] w);
    int n = 0;
    instr = w; instr_valid = 1'b1;
    while (!rdy64 && n < 20) begin step(); n++; end
    if (!rdy64) begin
      errors++; $display("FAIL issue_timeout: instr_ready stuck at 0 for %h", w);
    end
    step();
    instr_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic bad = 1'b0;
    rst = 1'b0; instr_valid = 1'b0; result_ready = 1'b1;
    step(); step();
    checks++; if (rv64 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rv64); end
    checks++; if (res64 !== 64'd0) begin errors++; $display("FAIL reset_result: got %h want 0", res64); end
    checks++; if (rd64 !== 5'd0 || ill64 !== 1'b0) begin errors++; $display("FAIL reset_rd_ill: got rd=%0d ill=%b want 0/0", rd64, ill64); end
    checks++; if (rdy64 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", rdy64); end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      if (dbg64 !== 64'd0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL reset_regs: some register nonzero, want all 0"); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_forward();
    result_ready = 1'b1;
    instr = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'b0010011); instr_valid = 1'b1;
    step();
    instr = enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd2, 7'b0110011);
    step();
    instr_valid = 1'b0;
    checks++; if (rv64 !== 1'b1 || res64 !== 64'd5) begin errors++; $display("FAIL fwd_first: got v=%b r=%0d want 1/5", rv64, res64); end
    step();
    checks++; if (res64 !== 64'd10 || rd64 !== 5'd2) begin errors++; $display("FAIL fwd_second: got r=%0d rd=%0d want 10/2", res64, rd64); end
    dbg_addr = 5'd2; #1;
    checks++; if (dbg64 !== 64'd10) begin errors++; $display("FAIL fwd_x2: got %0d want 10", dbg64); end
    step();
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_v [3] = '{64'd1, 64'd2, 64'd3};
    result_ready = 1'b0;
    instr = enc_i(12'd1, 5'd0, 3'd0, 5'd6, 7'b0010011); instr_valid = 1'b1;
    step();
    checks++; if (rdy64 !== 1'b1) begin errors++; $display("FAIL bp_ready_after1: got %b want 1", rdy64); end
    instr = enc_i(12'd2, 5'd0, 3'd0, 5'd7, 7'b0010011);
    step();
    instr = enc_i(12'd3, 5'd0, 3'd0, 5'd8, 7'b0010011);
    checks++; if (rdy64 !== 1'b0 || res64 !== 64'd1) begin errors++; $display("FAIL bp_stall: got rdy=%b r=%0d want 0/1", rdy64, res64); end
    step(); step();
    checks++; if (rdy64 !== 1'b0 || rv64 !== 1'b1 || res64 !== 64'd1) begin errors++; $display("FAIL bp_hold: got rdy=%b v=%b r=%0d want 0/1/1", rdy64, rv64, res64); end
    result_ready = 1'b1; #1;
    checks++; if (rdy64 !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", rdy64); end
    step();
    instr_valid = 1'b0;
    checks++; if (res64 !== 64'd2 || rd64 !== 5'd7) begin errors++; $display("FAIL bp_drain2: got r=%0d rd=%0d want 2/7", res64, rd64); end
    step();
    checks++; if (res64 !== 64'd3 || rd64 !== 5'd8 || rv64 !== 1'b1) begin errors++; $display("FAIL bp_drain3: got r=%0d rd=%0d v=%b want 3/8/1", res64, rd64, rv64); end
    step();
    checks++; if (rv64 !== 1'b0) begin errors++; $display("FAIL bp_empty: got v=%b want 0", rv64); end
    for (int i = 0; i < 3; i++) begin
      dbg_addr = 5'(6 + i); #1;
      checks++; if (dbg64 !== exp_v[i]) begin errors++; $display("FAIL bp_reg x%0d: got %0d want %0d", 6 + i, dbg64, exp_v[i]); end
    end
  endtask

  task automatic test_word_ops();
    result_ready = 1'b1;
    instr = enc_i(12'hFFF, 5'd0, 3'd0, 5'd3, 7'b0011011); instr_valid = 1'b1;  // ADDIW x3,x0,-1
    step();
    instr = enc_i(12'h01F, 5'd3, 3'd1, 5'd4, 7'b0011011);                     // SLLIW x4,x3,31
    step();
    instr = enc_i(12'h43F, 5'd4, 3'd5, 5'd5, 7'b0010011);                     // SRAI x5,x4,63
    step();
    instr_valid = 1'b0;
    step();
    checks++; if (res64 !== 64'hFFFF_FFFF_FFFF_FFFF || rd64 !== 5'd5) begin errors++; $display("FAIL w_srai_result: got %h rd=%0d want ffffffffffffffff/5", res64, rd64); end
    step();
    dbg_addr = 5'd3; #1;
    checks++; if (dbg64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL w_x3: got %h want ffffffffffffffff", dbg64); end
    dbg_addr = 5'd4; #1;
    checks++; if (dbg64 !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL w_x4: got %h want ffffffff80000000", dbg64); end
    dbg_addr = 5'd5; #1;
    checks++; if (dbg64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL w_x5: got %h want ffffffffffffffff", dbg64); end
    dbg_addr = 5'd3; #1;
    checks++; if (dbg32 !== 32'd0) begin errors++; $display("FAIL w_rv32_x3: got %h want 0", dbg32); end
  endtask

  task automatic test_illegal();
    result_ready = 1'b1;
    issue_one({7'd0, 5'd1, 5'd1, 3'b010, 5'd9, 7'b0100011});                   // store
    checks++; if (ill64 !== 1'b1 || res64 !== 64'd0) begin errors++; $display("FAIL ill_store: got ill=%b r=%h want 1/0", ill64, res64); end
    dbg_addr = 5'd9; #1;
    checks++; if (dbg64 !== 64'd0) begin errors++; $display("FAIL ill_store_x9: got %h want 0", dbg64); end

    issue_one(enc_r(7'b0000001, 5'd1, 5'd1, 3'd0, 5'd10, 7'b0110011));        // funct7=1
    checks++; if (ill64 !== 1'b1 || res64 !== 64'd0) begin errors++; $display("FAIL ill_f7: got ill=%b r=%h want 1/0", ill64, res64); end
    dbg_addr = 5'd10; #1;
    checks++; if (dbg64 !== 64'd0) begin errors++; $display("FAIL ill_f7_x10: got %h want 0", dbg64); end

    issue_one(enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd11, 7'b0111011));              // ADDW x11,x1,x1
    checks++; if (ill32 !== 1'b1 || res32 !== 32'd0) begin errors++; $display("FAIL ill_rv32_op32: got ill=%b r=%h want 1/0", ill32, res32); end
    checks++; if (ill64 !== 1'b0 || res64 !== 64'd10) begin errors++; $display("FAIL rv64_addw: got ill=%b r=%0d want 0/10", ill64, res64); end
    dbg_addr = 5'd11; #1;
    checks++; if (dbg32 !== 32'd0) begin errors++; $display("FAIL ill_rv32_x11: got %h want 0", dbg32); end

    issue_one(enc_i(12'd9, 5'd0, 3'd0, 5'd20, 7'b0010011));                   // ADDI x20,x0,9
    checks++; if (ill16 !== 1'b1 || res16 !== 64'd0) begin errors++; $display("FAIL ill_rve_rd20: got ill=%b r=%h want 1/0", ill16, res16); end
    checks++; if (ill64 !== 1'b0 || res64 !== 64'd9) begin errors++; $display("FAIL rv64_x20: got ill=%b r=%0d want 0/9", ill64, res64); end
    dbg_addr = 5'd1; #1;
    checks++; if (dbg16 !== 64'd5) begin errors++; $display("FAIL ill_rve_x1: got %0d want 5", dbg16); end
  endtask

  task automatic test_x0();
    result_ready = 1'b1;
    issue_one(enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'b0010011));
    checks++; if (res64 !== 64'd7 || rd64 !== 5'd0 || ill64 !== 1'b0) begin errors++; $display("FAIL x0_result: got r=%0d rd=%0d ill=%b want 7/0/0", res64, rd64, ill64); end
    step();
    dbg_addr = 5'd0; #1;
    checks++; if (dbg64 !== 64'd0) begin errors++; $display("FAIL x0_read: got %h want 0", dbg64); end
  endtask

  task automatic test_reset_inflight();
    logic bad = 1'b0;
    result_ready = 1'b1;
    instr = enc_i(12'd12, 5'd0, 3'd0, 5'd12, 7'b0010011); instr_valid = 1'b1;
    step();
    instr = enc_i(12'd13, 5'd0, 3'd0, 5'd13, 7'b0010011);
    step();
    instr_valid = 1'b0;
    rst = 1'b0;
    step();
    checks++; if (rv64 !== 1'b0 || rdy64 !== 1'b1) begin errors++; $display("FAIL rst_flight_flags: got v=%b rdy=%b want 0/1", rv64, rdy64); end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      if (dbg64 !== 64'd0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL rst_flight_regs: some register nonzero, want all 0"); end
    rst = 1'b1;
    step(); step();
    dbg_addr = 5'd13; #1;
    checks++; if (dbg64 !== 64'd0 || rv64 !== 1'b0) begin errors++; $display("FAIL rst_flight_late_wb: got x13=%0d v=%b want 0/0", dbg64, rv64); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_forward();
    test_backpressure();
    test_word_ops();
    test_illegal();
    test_x0();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
